// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared constants, state encoding and small helpers for the Ethernet receive
// frame path (eth_rx_frame_ctrl and eth_fcs_strip_pipe).
// -----------------------------------------------------------------------------
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;
  localparam int          FCS_LEN      = 4;

  // One extra stage beyond the FCS so the last data byte is still held when
  // dv drops, letting it go out tagged with eof.
  localparam int          PIPE_DEPTH   = FCS_LEN + 1;
  localparam logic [2:0]  PIPE_FULL    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DA       = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_DROP     = 3'd4
  } rx_state_e;

  // Byte idx of a MAC address in wire order (idx 0 = bits [47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac,
                                          input logic [2:0]  idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Saturating 16-bit increment for debug counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_fcs_strip_pipe.sv
// -----------------------------------------------------------------------------
// eth_fcs_strip_pipe
// 5-entry byte shift register used to hold back the trailing FCS. The oldest
// entry is presented on dout; the owner decides when to emit it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : shift din in (oldest entry falls out)
//   flush      : empty the pipe (takes priority over push for occupancy)
//   din        : incoming byte
//   dout       : oldest entry (valid when full)
//   full       : pipe holds PIPE_DEPTH entries
// -----------------------------------------------------------------------------
module eth_fcs_strip_pipe
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full
);

  logic [7:0] stage_r [PIPE_DEPTH];
  logic [2:0] cnt_r;

  assign full = (cnt_r == PIPE_FULL);
  assign dout = stage_r[PIPE_DEPTH-1];

  // Data shift: stage 0 is newest, stage PIPE_DEPTH-1 is oldest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        stage_r[i] <= 8'h00;
      end
    end else if (push) begin
      stage_r[0] <= din;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Occupancy: counts up to full, cleared on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 3'd0;
    end else if (flush) begin
      cnt_r <= 3'd0;
    end else if (push && !full) begin
      cnt_r <= cnt_r + 3'd1;
    end
  end

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// eth_rx_frame_ctrl
// GMII receive frame sequencer: locks on preamble/SFD, filters on destination
// MAC (board or broadcast), strips the FCS and delivers SA..payload bytes with
// sof/eof/err markers. Keeps saturating good/dropped frame counters.
// Ports:
//   gmii_rx_clk, sys_rst_n : clock, asynchronous active-low reset
//   rx_en                  : receive enable, sampled only in IDLE
//   gmii_rx_dv, gmii_rxd   : GMII receive stream
//   rec_data/valid/sof/eof/err : framed output byte stream (registered)
//   rx_busy                : sequencer not idle
//   frm_ok_cnt/frm_drop_cnt: saturating frame counters
// -----------------------------------------------------------------------------
module eth_rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h0011_2233_4455,
  parameter logic [10:0] MIN_LEN   = 11'd58,
  parameter logic [10:0] MAX_LEN   = 11'd1512,
  parameter logic [2:0]  PRE_MIN   = 3'd6
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst_n,
  input  logic        rx_en,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [7:0]  rec_data,
  output logic        rec_valid,
  output logic        rec_sof,
  output logic        rec_eof,
  output logic        rec_err,
  output logic        rx_busy,
  output logic [15:0] frm_ok_cnt,
  output logic [15:0] frm_drop_cnt
);

  rx_state_e   state_r;
  logic [2:0]  pre_cnt_r;
  logic [2:0]  byte_idx_r;
  logic        uc_match_r;
  logic        bc_match_r;
  logic [10:0] len_r;
  logic        sof_pend_r;

  logic [7:0]  rec_data_r;
  logic        rec_valid_r;
  logic        rec_sof_r;
  logic        rec_eof_r;
  logic        rec_err_r;
  logic        rx_busy_r;
  logic [15:0] frm_ok_cnt_r;
  logic [15:0] frm_drop_cnt_r;

  logic [7:0]  da_byte_s;
  logic        uc_next_s;
  logic        bc_next_s;
  logic        push_s;
  logic        flush_s;
  logic [7:0]  pipe_dout_s;
  logic        pipe_full_s;

  assign rec_data     = rec_data_r;
  assign rec_valid    = rec_valid_r;
  assign rec_sof      = rec_sof_r;
  assign rec_eof      = rec_eof_r;
  assign rec_err      = rec_err_r;
  assign rx_busy      = rx_busy_r;
  assign frm_ok_cnt   = frm_ok_cnt_r;
  assign frm_drop_cnt = frm_drop_cnt_r;

  // DA match tracking and pipe control decode.
  always_comb begin
    da_byte_s = mac_byte(BOARD_MAC, byte_idx_r);
    uc_next_s = uc_match_r & (gmii_rxd == da_byte_s);
    bc_next_s = bc_match_r & (gmii_rxd == ETH_BCAST[7:0]);
    if (state_r == ST_PAYLOAD) begin
      push_s  = gmii_rx_dv;
      // End of frame or oversize cut: whatever is left is FCS / discarded.
      flush_s = !gmii_rx_dv || (len_r == MAX_LEN);
    end else begin
      push_s  = 1'b0;
      flush_s = 1'b0;
    end
  end

  eth_fcs_strip_pipe u_pipe (
    .clk   (gmii_rx_clk),
    .rst_n (sys_rst_n),
    .push  (push_s),
    .flush (flush_s),
    .din   (gmii_rxd),
    .dout  (pipe_dout_s),
    .full  (pipe_full_s)
  );

  // Frame sequencer FSM with registered outputs and counters.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r        <= ST_IDLE;
      pre_cnt_r      <= 3'd0;
      byte_idx_r     <= 3'd0;
      uc_match_r     <= 1'b0;
      bc_match_r     <= 1'b0;
      len_r          <= 11'd0;
      sof_pend_r     <= 1'b0;
      rec_data_r     <= 8'h00;
      rec_valid_r    <= 1'b0;
      rec_sof_r      <= 1'b0;
      rec_eof_r      <= 1'b0;
      rec_err_r      <= 1'b0;
      rx_busy_r      <= 1'b0;
      frm_ok_cnt_r   <= 16'h0000;
      frm_drop_cnt_r <= 16'h0000;
    end else begin
      rec_valid_r <= 1'b0;
      rec_sof_r   <= 1'b0;
      rec_eof_r   <= 1'b0;
      rec_err_r   <= 1'b0;
      // Every state leaves for IDLE exactly when dv is low, so dv is the
      // next-state busy flag.
      rx_busy_r   <= gmii_rx_dv;
      case (state_r)
        ST_IDLE: begin
          if (gmii_rx_dv) begin
            if ((gmii_rxd == ETH_PREAMBLE) && rx_en) begin
              state_r   <= ST_PREAMBLE;
              pre_cnt_r <= 3'd1;
            end else begin
              state_r <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_r <= ST_IDLE;
          end else if (gmii_rxd == ETH_PREAMBLE) begin
            if (pre_cnt_r != 3'd7) begin
              pre_cnt_r <= pre_cnt_r + 3'd1;
            end
          end else if ((gmii_rxd == ETH_SFD) && (pre_cnt_r >= PRE_MIN)) begin
            state_r    <= ST_DA;
            byte_idx_r <= 3'd0;
            uc_match_r <= 1'b1;
            bc_match_r <= 1'b1;
          end else begin
            state_r        <= ST_DROP;
            frm_drop_cnt_r <= sat_inc16(frm_drop_cnt_r);
          end
        end
        ST_DA: begin
          if (!gmii_rx_dv) begin
            state_r        <= ST_IDLE;
            frm_drop_cnt_r <= sat_inc16(frm_drop_cnt_r);
          end else if (byte_idx_r == 3'd5) begin
            if (uc_next_s || bc_next_s) begin
              state_r    <= ST_PAYLOAD;
              len_r      <= 11'd0;
              sof_pend_r <= 1'b1;
            end else begin
              state_r        <= ST_DROP;
              frm_drop_cnt_r <= sat_inc16(frm_drop_cnt_r);
            end
          end else begin
            byte_idx_r <= byte_idx_r + 3'd1;
            uc_match_r <= uc_next_s;
            bc_match_r <= bc_next_s;
          end
        end
        ST_PAYLOAD: begin
          if (!gmii_rx_dv) begin
            state_r <= ST_IDLE;
            if (pipe_full_s) begin
              // Last data byte; the four bytes behind it are the FCS.
              rec_valid_r <= 1'b1;
              rec_data_r  <= pipe_dout_s;
              rec_sof_r   <= sof_pend_r;
              rec_eof_r   <= 1'b1;
              rec_err_r   <= (len_r < MIN_LEN);
              sof_pend_r  <= 1'b0;
              if (len_r < MIN_LEN) begin
                frm_drop_cnt_r <= sat_inc16(frm_drop_cnt_r);
              end else begin
                frm_ok_cnt_r <= sat_inc16(frm_ok_cnt_r);
              end
            end else begin
              frm_drop_cnt_r <= sat_inc16(frm_drop_cnt_r);
            end
          end else begin
            len_r <= len_r + 11'd1;
            if (pipe_full_s) begin
              rec_valid_r <= 1'b1;
              rec_data_r  <= pipe_dout_s;
              rec_sof_r   <= sof_pend_r;
              sof_pend_r  <= 1'b0;
            end
            // This byte makes the frame MAX_LEN+1 long: cut it off here.
            if (len_r == MAX_LEN) begin
              rec_eof_r      <= 1'b1;
              rec_err_r      <= 1'b1;
              state_r        <= ST_DROP;
              frm_drop_cnt_r <= sat_inc16(frm_drop_cnt_r);
            end
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rx_busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_frame_ctrl
// Directed testbench for eth_rx_frame_ctrl. Payload byte k after the DA
// carries pat(k); a monitor tracks every output byte against that pattern.
// -----------------------------------------------------------------------------
module tb_eth_rx_frame_ctrl;

  localparam logic [47:0] MAC   = 48'h0011_2233_4455;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_X = 48'h0011_2233_4456;

  logic        gmii_rx_clk = 1'b0;
  logic        sys_rst_n;
  logic        rx_en;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic [7:0]  rec_data;
  logic        rec_valid, rec_sof, rec_eof, rec_err, rx_busy;
  logic [15:0] frm_ok_cnt, frm_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ok   = 0;
  int exp_drop = 0;

  // Monitor accumulators and snapshot bases.
  int mon_valid = 0, mon_sof = 0, mon_eof = 0, mon_err = 0, mon_bad = 0;
  int mon_se = 0, mon_idx = 0, mon_eof_idx = 0;
  int b_valid, b_sof, b_eof, b_err, b_bad, b_se;

  eth_rx_frame_ctrl dut (
    .gmii_rx_clk  (gmii_rx_clk),
    .sys_rst_n    (sys_rst_n),
    .rx_en        (rx_en),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .rec_data     (rec_data),
    .rec_valid    (rec_valid),
    .rec_sof      (rec_sof),
    .rec_eof      (rec_eof),
    .rec_err      (rec_err),
    .rx_busy      (rx_busy),
    .frm_ok_cnt   (frm_ok_cnt),
    .frm_drop_cnt (frm_drop_cnt)
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  function automatic logic [7:0] pat(input int k);
    int t;
    t = k * 7 + 3;
    return t[7:0];
  endfunction

  // Output monitor, sampled on the falling edge.
  always @(negedge gmii_rx_clk) begin
    if (rec_valid) begin
      if (rec_sof) mon_idx = 1;
      else         mon_idx = mon_idx + 1;
      if (rec_data !== pat(mon_idx)) mon_bad = mon_bad + 1;
      mon_valid = mon_valid + 1;
      if (rec_sof) mon_sof = mon_sof + 1;
      if (rec_sof && rec_eof) mon_se = mon_se + 1;
      if (rec_eof) begin
        mon_eof     = mon_eof + 1;
        mon_eof_idx = mon_idx;
        if (rec_err) mon_err = mon_err + 1;
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge gmii_rx_clk);
    gmii_rx_dv = v;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic send_hdr(input int n_pre, input logic [7:0] sfd, input logic [47:0] da);
    logic [47:0] sh;
    for (int i = 0; i < n_pre; i++) drive(1'b1, 8'h55);
    drive(1'b1, sfd);
    for (int i = 0; i < 6; i++) begin
      sh = da << (8 * i);
      drive(1'b1, sh[47:40]);
    end
  endtask

  task automatic send_bytes(input int a, input int b);
    for (int k = a; k <= b; k++) drive(1'b1, pat(k));
  endtask

  task automatic send_frame(input int n_pre, input logic [47:0] da, input int n);
    send_hdr(n_pre, 8'hD5, da);
    send_bytes(1, n);
    drive(1'b0, 8'h00);
  endtask

  task automatic snap();
    b_valid = mon_valid; b_sof = mon_sof; b_eof = mon_eof;
    b_err = mon_err; b_bad = mon_bad; b_se = mon_se;
  endtask

  // Checks common to the end of every scenario: counters and idle flag.
  task automatic test_counters(input string tag);
    n_checks++; if (frm_ok_cnt !== exp_ok[15:0]) begin n_fail++;
      $display("FAIL %s ok_cnt: got %0d expected %0d", tag, frm_ok_cnt, exp_ok); end
    n_checks++; if (frm_drop_cnt !== exp_drop[15:0]) begin n_fail++;
      $display("FAIL %s drop_cnt: got %0d expected %0d", tag, frm_drop_cnt, exp_drop); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++;
      $display("FAIL %s rx_busy: got %0b expected 0", tag, rx_busy); end
    n_checks++; if (mon_bad - b_bad !== 0) begin n_fail++;
      $display("FAIL %s data: got %0d bad bytes expected 0", tag, mon_bad - b_bad); end
  endtask

  // Checks for one delivered frame of n_out bytes ending with err flag e.
  task automatic test_frame_out(input string tag, input int n_out, input int e);
    n_checks++; if (mon_valid - b_valid !== n_out) begin n_fail++;
      $display("FAIL %s valid_cnt: got %0d expected %0d", tag, mon_valid - b_valid, n_out); end
    n_checks++; if (mon_sof - b_sof !== 1 || mon_eof - b_eof !== 1) begin n_fail++;
      $display("FAIL %s sof/eof: got %0d/%0d expected 1/1", tag, mon_sof - b_sof, mon_eof - b_eof); end
    n_checks++; if (mon_eof_idx !== n_out) begin n_fail++;
      $display("FAIL %s eof_pos: got %0d expected %0d", tag, mon_eof_idx, n_out); end
    n_checks++; if (mon_err - b_err !== e) begin n_fail++;
      $display("FAIL %s err: got %0d expected %0d", tag, mon_err - b_err, e); end
  endtask

  task automatic test_no_out(input string tag);
    n_checks++; if (mon_valid - b_valid !== 0 || mon_eof - b_eof !== 0) begin n_fail++;
      $display("FAIL %s no_output: got %0d bytes %0d eof expected 0 0", tag,
               mon_valid - b_valid, mon_eof - b_eof); end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; rx_en = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    repeat (3) @(negedge gmii_rx_clk);
    n_checks++; if ({rec_data, rec_valid, rec_sof, rec_eof, rec_err, rx_busy} !== 13'h0) begin
      n_fail++; $display("FAIL reset outputs: got %h expected 0",
                         {rec_data, rec_valid, rec_sof, rec_eof, rec_err, rx_busy}); end
    sys_rst_n = 1'b1;
    idle(2);
    snap();
    test_counters("reset");
  endtask

  task automatic test_unicast();
    snap();
    send_frame(7, MAC, 60); idle(3);
    exp_ok++;
    test_frame_out("unicast", 56, 0);
    test_counters("unicast");
    // PRE_MIN boundary: exactly six 0x55 is enough.
    snap();
    send_frame(6, MAC, 60); idle(3);
    exp_ok++;
    test_frame_out("pre6", 56, 0);
    test_counters("pre6");
  endtask

  task automatic test_broadcast_and_filter();
    snap();
    send_frame(7, BCAST, 100); idle(3);
    exp_ok++;
    test_frame_out("bcast", 96, 0);
    test_counters("bcast");
    snap();
    send_frame(7, MAC_X, 60); idle(3);
    exp_drop++;
    test_no_out("da_miss");
    test_counters("da_miss");
  endtask

  task automatic test_preamble_errors();
    snap();
    send_frame(4, MAC, 60); idle(3);
    exp_drop++;
    test_no_out("pre4");
    test_counters("pre4");
    snap();
    send_frame(5, MAC, 60); idle(3);
    exp_drop++;
    test_no_out("pre5");
    test_counters("pre5");
    snap();
    drive(1'b1, 8'h55); drive(1'b1, 8'h12); send_bytes(1, 10); drive(1'b0, 8'h00); idle(3);
    exp_drop++;
    test_no_out("pre_bad");
    test_counters("pre_bad");
  endtask

  task automatic test_short_frames();
    snap();
    send_frame(7, MAC, 20); idle(3);
    exp_drop++;
    test_frame_out("short20", 16, 1);
    test_counters("short20");
    snap();
    send_frame(7, MAC, 5); idle(3);
    exp_drop++;
    test_frame_out("short5", 1, 1);
    n_checks++; if (mon_se - b_se !== 1) begin n_fail++;
      $display("FAIL short5 sof_eof_same: got %0d expected 1", mon_se - b_se); end
    test_counters("short5");
    snap();
    send_frame(7, MAC, 3); idle(3);
    exp_drop++;
    test_no_out("short3");
    test_counters("short3");
    // len 57 is one below MIN_LEN, len 58 is exactly legal.
    snap();
    send_frame(7, MAC, 57); idle(3);
    exp_drop++;
    test_frame_out("len57", 53, 1);
    test_counters("len57");
    snap();
    send_frame(7, MAC, 58); idle(3);
    exp_ok++;
    test_frame_out("len58", 54, 0);
    test_counters("len58");
  endtask

  task automatic test_oversize();
    snap();
    send_frame(7, MAC, 1600); idle(3);
    exp_drop++;
    test_frame_out("oversize", 1508, 1);
    test_counters("oversize");
    snap();
    send_frame(7, MAC, 60); idle(3);
    exp_ok++;
    test_frame_out("after_ovs", 56, 0);
    test_counters("after_ovs");
  endtask

  task automatic test_back_to_back();
    // Frame 1: rx_en drops mid-frame, frame still completes.
    snap();
    send_hdr(7, 8'hD5, MAC);
    send_bytes(1, 30);
    rx_en = 1'b0;
    send_bytes(31, 60);
    drive(1'b0, 8'h00);
    // Frame 2 starts right after a single idle cycle and must be ignored.
    send_frame(7, MAC, 60); idle(3);
    exp_ok++;
    test_frame_out("b2b_f1", 56, 0);
    test_counters("b2b_f2");
    // Frame 3: reset pulsed mid-frame.
    rx_en = 1'b1;
    snap();
    send_hdr(7, 8'hD5, MAC);
    send_bytes(1, 20);
    #1;
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++;
      $display("FAIL midframe rx_busy: got %0b expected 1", rx_busy); end
    n_checks++; if (mon_valid - b_valid !== 14) begin n_fail++;
      $display("FAIL midframe valid_cnt: got %0d expected 14", mon_valid - b_valid); end
    sys_rst_n = 1'b0;
    #1;
    exp_ok = 0; exp_drop = 0;
    n_checks++; if ({rec_data, rec_valid, rec_sof, rec_eof, rec_err, rx_busy} !== 13'h0
                    || frm_ok_cnt !== 16'h0 || frm_drop_cnt !== 16'h0) begin
      n_fail++; $display("FAIL midreset outputs: got %h %0d %0d expected 0 0 0",
                         {rec_data, rec_valid, rec_sof, rec_eof, rec_err, rx_busy},
                         frm_ok_cnt, frm_drop_cnt); end
    snap();
    send_bytes(21, 22);
    sys_rst_n = 1'b1;
    send_bytes(23, 30);
    drive(1'b0, 8'h00); idle(3);
    test_no_out("rst_abandon");
    test_counters("rst_abandon");
    // Frame 4: clean reception after reset.
    snap();
    send_frame(7, MAC, 60); idle(3);
    exp_ok++;
    test_frame_out("post_rst", 56, 0);
    test_counters("post_rst");
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_broadcast_and_filter();
    test_preamble_errors();
    test_short_frames();
    test_oversize();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
